// File: rtl/task_6_divider.sv
// task_6_divider: debounced-key restoring divider showing quotient/remainder on LEDs.
// Define DIV_SIGNED_EN for two's-complement operands (sign applied around the unsigned core).
module task_6_divider #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             key0_rst,
  input  logic             key1_div,
  input  logic [WIDTH-1:0] sw1,
  input  logic [WIDTH-1:0] sw2,
  output logic [WIDTH-1:0] ledr1,
  output logic [WIDTH-1:0] ledr2,
  output logic [WIDTH-1:0] ledg,
  output logic [WIDTH-1:0] ledr3,
  output logic             led_busy,
  output logic             led_err
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state;
  logic             key_s1, key_s2, key_deb, go;
  logic [DW-1:0]    deb_cnt;
  logic [WIDTH-1:0] dvd, dvs, rem, rem_nxt, q_nxt, a_mag, b_mag, q_out, r_out;
  logic [WIDTH:0]   shifted;
  logic [CW-1:0]    cnt;
  logic             ge;
  assign ledr1 = sw1;
  assign ledr2 = sw2;
  // go fires on the edge where the debounced level flips from released to pressed
  assign go = key_deb && !key_s2 && deb_cnt == DW'(DEBOUNCE_CYCLES - 1);
  always_ff @(posedge clk or negedge key0_rst)
    if (!key0_rst) begin
      key_s1  <= 1'b1;
      key_s2  <= 1'b1;
      key_deb <= 1'b1;
      deb_cnt <= '0;
    end else begin
      key_s1  <= key1_div;
      key_s2  <= key_s1;
      deb_cnt <= (key_s2 != key_deb && deb_cnt != DW'(DEBOUNCE_CYCLES - 1)) ? deb_cnt + 1'b1 : '0;
      if (key_s2 != key_deb && deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) key_deb <= key_s2;
    end
  // the top bit of the shifted remainder forces a subtract, so the remainder reg stays WIDTH wide
  assign shifted = {rem, dvd[WIDTH-1]};
  assign ge      = shifted[WIDTH] || shifted[WIDTH-1:0] >= dvs;
  assign rem_nxt = ge ? shifted[WIDTH-1:0] - dvs : shifted[WIDTH-1:0];
  assign q_nxt   = {dvd[WIDTH-2:0], ge};
`ifdef DIV_SIGNED_EN
  logic q_neg, r_neg;
  assign a_mag = sw1[WIDTH-1] ? -sw1 : sw1;
  assign b_mag = sw2[WIDTH-1] ? -sw2 : sw2;
  assign q_out = q_neg ? -q_nxt : q_nxt;
  assign r_out = r_neg ? -rem_nxt : rem_nxt;
  always_ff @(posedge clk or negedge key0_rst)
    if (!key0_rst) begin
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (state == IDLE && go) begin
      q_neg <= sw1[WIDTH-1] ^ sw2[WIDTH-1];
      r_neg <= sw1[WIDTH-1];
    end
`else
  assign a_mag = sw1;
  assign b_mag = sw2;
  assign q_out = q_nxt;
  assign r_out = rem_nxt;
`endif
  always_ff @(posedge clk or negedge key0_rst)
    if (!key0_rst) begin
      state    <= IDLE;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      cnt      <= '0;
      ledg     <= '0;
      ledr3    <= '0;
      led_busy <= 1'b0;
      led_err  <= 1'b0;
    end else if (state == IDLE) begin
      if (go && sw2 != '0) begin
        dvd      <= a_mag;
        dvs      <= b_mag;
        rem      <= '0;
        cnt      <= CW'(WIDTH);
        led_busy <= 1'b1;
        state    <= RUN;
      end else if (go) begin
        ledg    <= '1;
        ledr3   <= sw1;
        led_err <= 1'b1;
      end
    end else begin
      dvd <= q_nxt;
      rem <= rem_nxt;
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        ledg     <= q_out;
        ledr3    <= r_out;
        led_err  <= 1'b0;
        led_busy <= 1'b0;
        state    <= IDLE;
      end
    end
endmodule

// File: tb/tb_task_6_divider.sv
// tb_task_6_divider: directed tests of the debounced shift-subtract divider.
module tb_task_6_divider;
  logic       clk = 0, key0_rst = 0, key1_div = 1;
  logic [7:0] sw1 = 0, sw2 = 0;
  logic [7:0] ledr1, ledr2, ledg, ledr3;
  logic       led_busy, led_err;
  int passed = 0, total = 0;

  task_6_divider #(.WIDTH(8), .DEBOUNCE_CYCLES(16)) dut (
    .clk(clk), .key0_rst(key0_rst), .key1_div(key1_div), .sw1(sw1), .sw2(sw2),
    .ledr1(ledr1), .ledr2(ledr2), .ledg(ledg), .ledr3(ledr3),
    .led_busy(led_busy), .led_err(led_err));

  always #5 clk = ~clk;

  // press and hold; returns how many sampled cycles led_busy was high (0 if it never rose)
  task automatic press_wait(input logic [7:0] a, input logic [7:0] b, output int bcyc);
    int n;
    sw1 = a; sw2 = b; key1_div = 0; bcyc = 0; n = 0;
    while (!led_busy && n < 60) begin @(negedge clk); n++; end
    while (led_busy && bcyc < 100) begin bcyc++; @(negedge clk); end
  endtask

  task automatic release_key();
    key1_div = 1;
    repeat (30) @(negedge clk);
  endtask

  task automatic do_div(input string nm, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er, input logic ee, input int eb);
    int bc;
    press_wait(a, b, bc);
    total++; if (bc !== eb) $display("FAIL %s busy_cycles got %0d exp %0d", nm, bc, eb); else passed++;
    total++; if (ledg !== eq) $display("FAIL %s ledg got %h exp %h", nm, ledg, eq); else passed++;
    total++; if (ledr3 !== er) $display("FAIL %s ledr3 got %h exp %h", nm, ledr3, er); else passed++;
    total++; if (led_err !== ee) $display("FAIL %s led_err got %b exp %b", nm, led_err, ee); else passed++;
    release_key();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (ledg !== 8'h00) $display("FAIL rst_ledg got %h exp 00", ledg); else passed++;
    total++; if (ledr3 !== 8'h00) $display("FAIL rst_ledr3 got %h exp 00", ledr3); else passed++;
    total++; if (led_busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", led_busy); else passed++;
    total++; if (led_err !== 1'b0) $display("FAIL rst_err got %b exp 0", led_err); else passed++;
    key0_rst = 1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic();
    int bc;
    press_wait(8'd200, 8'd7, bc);
    total++; if (bc !== 8) $display("FAIL basic_busy got %0d exp 8", bc); else passed++;
    total++; if (ledg !== 8'd28) $display("FAIL basic_ledg got %0d exp 28", ledg); else passed++;
    total++; if (ledr3 !== 8'd4) $display("FAIL basic_ledr3 got %0d exp 4", ledr3); else passed++;
    total++; if (led_err !== 1'b0) $display("FAIL basic_err got %b exp 0", led_err); else passed++;
    total++; if (ledr1 !== 8'd200) $display("FAIL basic_ledr1 got %0d exp 200", ledr1); else passed++;
    total++; if (ledr2 !== 8'd7) $display("FAIL basic_ledr2 got %0d exp 7", ledr2); else passed++;
    release_key();
  endtask

  task automatic test_back_to_back();
    do_div("b2b_5_9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 8);
    do_div("b2b_255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 8);
    do_div("b2b_255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 8);
  endtask

  task automatic test_div_zero();
    do_div("dz_100_0", 8'd100, 8'd0, 8'd255, 8'd100, 1'b1, 0);
    do_div("dz_after_9_3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 8);
  endtask

  task automatic test_glitch();
    int rises = 0;
    key1_div = 0;
    repeat (5) @(negedge clk);
    key1_div = 1;
    repeat (40) begin @(negedge clk); if (led_busy) rises++; end
    total++; if (rises !== 0) $display("FAIL glitch_busy got %0d exp 0", rises); else passed++;
    total++; if (ledg !== 8'd3) $display("FAIL glitch_ledg got %0d exp 3", ledg); else passed++;
  endtask

  task automatic test_bounce_hold();
    int rises = 0;
    logic prev = 0;
    int pat [6] = '{2, 1, 3, 2, 1, 1};
    sw1 = 8'd50; sw2 = 8'd6;
    for (int i = 0; i < 6; i++) begin
      key1_div = (i % 2) ? 1'b1 : 1'b0;
      repeat (pat[i]) @(negedge clk);
    end
    key1_div = 0;
    repeat (200) begin
      @(negedge clk);
      if (led_busy && !prev) rises++;
      prev = led_busy;
      if (led_busy) sw1 = 8'd99;
    end
    total++; if (rises !== 1) $display("FAIL bounce_divisions got %0d exp 1", rises); else passed++;
    total++; if (ledg !== 8'd8) $display("FAIL bounce_ledg got %0d exp 8", ledg); else passed++;
    total++; if (ledr3 !== 8'd2) $display("FAIL bounce_ledr3 got %0d exp 2", ledr3); else passed++;
    release_key();
  endtask

  task automatic test_reset_mid_run();
    int n = 0, bad = 0;
    sw1 = 8'd77; sw2 = 8'd5; key1_div = 0;
    while (!led_busy && n < 60) begin @(negedge clk); n++; end
    total++; if (led_busy !== 1'b1) $display("FAIL midrst_start got %b exp 1", led_busy); else passed++;
    repeat (3) @(posedge clk);
    #3 key0_rst = 0;
    #1;
    total++; if (ledg !== 8'h00) $display("FAIL midrst_ledg got %h exp 00", ledg); else passed++;
    total++; if (ledr3 !== 8'h00) $display("FAIL midrst_ledr3 got %h exp 00", ledr3); else passed++;
    total++; if (led_busy !== 1'b0) $display("FAIL midrst_busy got %b exp 0", led_busy); else passed++;
    key1_div = 1;
    repeat (3) @(posedge clk);
    #3 key0_rst = 1;
    repeat (40) begin @(negedge clk); if (led_busy || ledg !== 8'h00) bad++; end
    total++; if (bad !== 0) $display("FAIL midrst_no_completion got %0d exp 0", bad); else passed++;
    do_div("midrst_next_20_6", 8'd20, 8'd6, 8'd3, 8'd2, 1'b0, 8);
  endtask

  task automatic test_signed();
    do_div("s_m7_2", 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 8);
    do_div("s_7_m2", 8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 8);
    do_div("s_m128_m1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 8);
    do_div("s_dz", 8'hF0, 8'h00, 8'hFF, 8'hF0, 1'b1, 0);
  endtask

  initial begin
    test_reset();
`ifdef DIV_SIGNED_EN
    test_signed();
`else
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_glitch();
    test_bounce_hold();
    test_reset_mid_run();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/task_6_divider.md
Name: task_6_divider

Overview:
- Board-level companion to the adder task: the inverse arithmetic direction, realised sequentially.
- On a debounced press of KEY1, divides the switch operand sw1 by sw2 with a shift-subtract divider over WIDTH cycles.
- Shows quotient on green LEDs and remainder on a third red LED bank; flags divide-by-zero.
- Debounce and press detection are internal, so the block is self-contained on the board top.

Parameters:
- WIDTH, 8, operand, quotient and remainder width.
- DEBOUNCE_CYCLES, 16, consecutive stable samples needed to accept a key level change (use about 250000 on the board at 50 MHz).

Ports:
- clk  input  1  system clock; all flops on its rising edge.
- key0_rst  input  1  reset; asynchronous, active-low (key pressed = 0).
- key1_div  input  1  raw push-button, active-low, asynchronous to clk.
- sw1  input  WIDTH  dividend.
- sw2  input  WIDTH  divisor.
- ledr1  output  WIDTH  combinational mirror of sw1.
- ledr2  output  WIDTH  combinational mirror of sw2.
- ledg  output  WIDTH  registered quotient.
- ledr3  output  WIDTH  registered remainder.
- led_busy  output  1  high while a division is running.
- led_err  output  1  high when the last completed division had sw2 = 0.

Behaviour:
- Reset (key0_rst = 0, asynchronous assert):
  - ledg = 0, ledr3 = 0, led_busy = 0, led_err = 0.
  - FSM goes to IDLE, debounce counter = 0, debounced key state = released.
  - Reset deassertion takes effect at the next clk edge.
- Key path:
  - Two-flop synchroniser on key1_div.
  - Debounced level changes only after DEBOUNCE_CYCLES consecutive synchronised samples differ from the current debounced level. Any bounce resets the counter.
  - The go pulse is one cycle long, on the debounced released-to-pressed transition. Holding the key produces one go only.
  - A new go requires a debounced release first.
- FSM states: IDLE, RUN.
  - IDLE, go, sw2 != 0:
    - Latch sw1 and sw2 into internal registers.
    - Clear the partial remainder; load the iteration count with WIDTH.
    - led_busy <= 1; go to RUN.
  - IDLE, go, sw2 == 0:
    - In the same edge: ledg <= all ones, ledr3 <= sw1, led_err <= 1.
    - Stay in IDLE; led_busy stays 0.
  - RUN, each cycle (restoring step):
    - Shift {remainder, dividend} left by 1.
    - If remainder >= divisor, subtract the divisor and set the quotient LSB to 1.
    - Decrement the count.
    - Remainder datapath is WIDTH+1 bits, so there is no overflow at full-scale divisors.
  - RUN, final (WIDTH-th) step:
    - Same edge: ledg <= quotient, ledr3 <= remainder, led_err <= 0, led_busy <= 0.
    - Return to IDLE.
- Latency: the result is visible exactly WIDTH edges after the edge that latched the operands (8 for the default).
- Output hold:
  - ledg, ledr3 and led_err hold their previous values throughout RUN and only update at completion.
  - Switch changes during RUN do not affect the result (operands are latched).
- Presses during RUN: go is ignored (dropped, not queued).
- Reset mid-RUN: aborts immediately and all outputs return to reset values.
- Unsigned arithmetic throughout unless the optional feature is enabled.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- Defined: sw1 and sw2 are two's complement.
  - Magnitudes go through the same unsigned core. Quotient is truncated toward zero and negated if the operand signs differ.
  - Remainder takes the dividend's sign; latency is unchanged.
  - -128 / -1 (WIDTH 8) gives ledg = 0x80, ledr3 = 0, no error.
  - Divide-by-zero: ledg = all ones, ledr3 = sw1, led_err = 1.
- Undefined: purely unsigned; no sign logic is synthesised.

Test Plan:
- sw1 = 200, sw2 = 7, clean press → led_busy high for 8 cycles, then ledg = 28, ledr3 = 4, led_err = 0. ledr1 = 200 and ledr2 = 7 at all times.
- Back-to-back divisions: 5/9 gives ledg = 0, ledr3 = 5; after release, 255/1 gives ledg = 255, ledr3 = 0; 255/255 gives ledg = 1, ledr3 = 0.
- sw1 = 100, sw2 = 0, press → ledg = 255, ledr3 = 100, led_err = 1, led_busy never asserts. A following 9/3 gives ledg = 3, ledr3 = 0, led_err = 0.
- Debounce:
  - 5-cycle low glitch with DEBOUNCE_CYCLES = 16 → no go, outputs unchanged.
  - Bouncing press then held low for 200 cycles → exactly one division.
  - Second press during RUN → ignored; the result matches the first operands even if sw1 is changed mid-RUN.
- key0_rst pulsed low 3 cycles into RUN, asynchronous to clk → all outputs 0 immediately. No completion occurs afterwards; the next press works normally.
- With DIV_SIGNED_EN:
  - -7/2 (0xF9/0x02) → ledg = 0xFD, ledr3 = 0xFF.
  - 7/-2 → ledg = 0xFD, ledr3 = 0x01.
  - -128/-1 → ledg = 0x80, ledr3 = 0.
